// File: rtl/arcade_input_mapper.sv
// Player-input front end: maps hps_io joystick words to per-player arcade controls with
// tick-based debounce, SOCD neutralisation, coin pulse shaping, autofire and pause toggle.
module arcade_input_mapper #(
   parameter int NUM_PLAYERS = 2,
   parameter int TICK_DIV    = 12000,
   parameter int DEB_TICKS   = 4,
   parameter int COIN_TICKS  = 50,
   parameter int AF_TICKS    = 33,
   parameter int BIT_RIGHT   = 0,
   parameter int BIT_LEFT    = 1,
   parameter int BIT_FIRE    = 4,
   parameter int BIT_START   = 5,
   parameter int BIT_COIN    = 7,
   parameter int BIT_PAUSE   = 8
) (
   input  logic                      clk_sys,
   input  logic                      reset,
   input  logic [16*NUM_PLAYERS-1:0] joy_in,
   input  logic                      mode_indep,
   input  logic [NUM_PLAYERS-1:0]    autofire_en,
   output logic [NUM_PLAYERS-1:0]    p_left,
   output logic [NUM_PLAYERS-1:0]    p_right,
   output logic [NUM_PLAYERS-1:0]    p_fire,
   output logic [NUM_PLAYERS-1:0]    p_start,
   output logic                      coin,
   output logic                      pause
);

   // Raw/stable signal layout: four per player, then coin and pause.
   localparam int NS        = 4 * NUM_PLAYERS + 2;
   localparam int SIG_LEFT  = 0;
   localparam int SIG_RIGHT = 1;
   localparam int SIG_FIRE  = 2;
   localparam int SIG_START = 3;
   localparam int SIG_COIN  = 4 * NUM_PLAYERS;
   localparam int SIG_PAUSE = 4 * NUM_PLAYERS + 1;

   localparam int TW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
   localparam int DW = (DEB_TICKS > 1)  ? $clog2(DEB_TICKS)  : 1;
   localparam int CW = (COIN_TICKS > 1) ? $clog2(COIN_TICKS) : 1;
   localparam int AW = (AF_TICKS > 1)   ? $clog2(AF_TICKS)   : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'((DEB_TICKS > 0) ? DEB_TICKS - 1 : 0);
   localparam logic [CW-1:0] COIN_LAST = CW'(COIN_TICKS - 1);
   localparam logic [AW-1:0] AF_LAST   = AW'(AF_TICKS - 1);

   typedef enum logic [1:0] {
      COIN_IDLE,
      COIN_PULSE,
      COIN_WAIT_REL
   } coin_state_e;

   // ------------------------------------------------------------------
   // Tick generator
   // ------------------------------------------------------------------
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;
   logic          tick_dly_q, tick_dly_d;

   always_comb begin
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      // Stage-2 logic sees stable values one cycle late, so it uses a tick aligned to them.
      tick_dly_d = tick;
   end

   // ------------------------------------------------------------------
   // Raw mapping
   // ------------------------------------------------------------------
   logic [15:0]   pad_or;
   logic [NS-1:0] raw;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      pad_or = '0;
      raw    = '0;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
         pad_or = pad_or | joy_in[16*k +: 16];
      end
      for (int k = 0; k < NUM_PLAYERS; k++) begin
         if (mode_indep) begin
            raw[4*k + SIG_LEFT]  = joy_in[16*k + BIT_LEFT];
            raw[4*k + SIG_RIGHT] = joy_in[16*k + BIT_RIGHT];
            raw[4*k + SIG_FIRE]  = joy_in[16*k + BIT_FIRE];
            raw[4*k + SIG_START] = joy_in[16*k + BIT_START];
         end else begin
            raw[4*k + SIG_LEFT]  = pad_or[BIT_LEFT];
            raw[4*k + SIG_RIGHT] = pad_or[BIT_RIGHT];
            raw[4*k + SIG_FIRE]  = pad_or[BIT_FIRE];
            raw[4*k + SIG_START] = (k < 2) ? pad_or[BIT_START + k] : 1'b0;
         end
      end
      raw[SIG_COIN]  = pad_or[BIT_COIN];
      raw[SIG_PAUSE] = pad_or[BIT_PAUSE];
   end

   // Pad bits outside the map are deliberately ignored.
   logic pad_unused;
   assign pad_unused = ^pad_or;

   // ------------------------------------------------------------------
   // Debounce
   // ------------------------------------------------------------------
   logic [NS-1:0] stable_q, stable_d;
   logic [DW-1:0] deb_cnt_q [NS];
   logic [DW-1:0] deb_cnt_d [NS];

   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NS; i++) begin
         deb_cnt_d[i] = deb_cnt_q[i];
         if (DEB_TICKS == 0) begin
            stable_d[i]  = raw[i];
            deb_cnt_d[i] = '0;
         end else if (tick) begin
            if (raw[i] == stable_q[i]) begin
               deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
               stable_d[i]  = raw[i];
               deb_cnt_d[i] = '0;
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stable-signal views and edge history
   // ------------------------------------------------------------------
   logic [NUM_PLAYERS-1:0] st_left, st_right, st_fire, st_start;
   logic [NUM_PLAYERS-1:0] fire_prev_q, fire_prev_d;
   logic                   st_coin, st_pause;
   logic                   coin_prev_q, coin_prev_d;
   logic                   pause_prev_q, pause_prev_d;

   always_comb begin
      for (int k = 0; k < NUM_PLAYERS; k++) begin
         st_left[k]  = stable_q[4*k + SIG_LEFT];
         st_right[k] = stable_q[4*k + SIG_RIGHT];
         st_fire[k]  = stable_q[4*k + SIG_FIRE];
         st_start[k] = stable_q[4*k + SIG_START];
      end
      st_coin      = stable_q[SIG_COIN];
      st_pause     = stable_q[SIG_PAUSE];
      fire_prev_d  = st_fire;
      coin_prev_d  = st_coin;
      pause_prev_d = st_pause;
   end

   // ------------------------------------------------------------------
   // Coin pulse FSM
   // ------------------------------------------------------------------
   coin_state_e   coin_state_q, coin_state_d;
   logic [CW-1:0] coin_cnt_q, coin_cnt_d;
   logic          coin_q, coin_d;

   always_comb begin
      coin_state_d = coin_state_q;
      coin_cnt_d   = coin_cnt_q;
      case (coin_state_q)
         COIN_IDLE: begin
            if (st_coin && !coin_prev_q) begin
               coin_state_d = COIN_PULSE;
               coin_cnt_d   = '0;
            end
         end
         COIN_PULSE: begin
            if (tick_dly_q) begin
               if (coin_cnt_q == COIN_LAST) begin
                  coin_state_d = COIN_WAIT_REL;
                  coin_cnt_d   = '0;
               end else begin
                  coin_cnt_d = coin_cnt_q + 1'b1;
               end
            end
         end
         COIN_WAIT_REL: begin
            if (!st_coin) begin
               coin_state_d = COIN_IDLE;
            end
         end
         default: begin
            coin_state_d = COIN_IDLE;
            coin_cnt_d   = '0;
         end
      endcase
      coin_d = (coin_state_d == COIN_PULSE);
   end

   // ------------------------------------------------------------------
   // Per-player outputs: SOCD, start, autofire
   // ------------------------------------------------------------------
   logic [NUM_PLAYERS-1:0] p_left_q,  p_left_d;
   logic [NUM_PLAYERS-1:0] p_right_q, p_right_d;
   logic [NUM_PLAYERS-1:0] p_start_q, p_start_d;
   logic [NUM_PLAYERS-1:0] p_fire_q,  p_fire_d;
   logic [AW-1:0]          af_phase_q [NUM_PLAYERS];
   logic [AW-1:0]          af_phase_d [NUM_PLAYERS];

   always_comb begin
      p_left_d  = st_left  & ~st_right;
      p_right_d = st_right & ~st_left;
      p_start_d = st_start;
      p_fire_d  = p_fire_q;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
         af_phase_d[k] = af_phase_q[k];
         if (!autofire_en[k] || !st_fire[k]) begin
            p_fire_d[k]   = st_fire[k];
            af_phase_d[k] = '0;
         end else if (!fire_prev_q[k]) begin
            p_fire_d[k]   = 1'b1;
            af_phase_d[k] = '0;
         end else if (tick_dly_q) begin
            if (af_phase_q[k] == AF_LAST) begin
               p_fire_d[k]   = ~p_fire_q[k];
               af_phase_d[k] = '0;
            end else begin
               af_phase_d[k] = af_phase_q[k] + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Pause toggle
   // ------------------------------------------------------------------
   logic pause_q, pause_d;

   always_comb begin
      pause_d = pause_q ^ (st_pause & ~pause_prev_q);
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         tick_cnt_q   <= '0;
         tick_dly_q   <= 1'b0;
         stable_q     <= '0;
         fire_prev_q  <= '0;
         coin_prev_q  <= 1'b0;
         pause_prev_q <= 1'b0;
         coin_state_q <= COIN_IDLE;
         coin_cnt_q   <= '0;
         coin_q       <= 1'b0;
         p_left_q     <= '0;
         p_right_q    <= '0;
         p_start_q    <= '0;
         p_fire_q     <= '0;
         pause_q      <= 1'b0;
         // NOTE: these small counter arrays are flops, not RAM, so clearing them on reset is cheap.
         for (int i = 0; i < NS; i++) begin
            deb_cnt_q[i] <= '0;
         end
         for (int k = 0; k < NUM_PLAYERS; k++) begin
            af_phase_q[k] <= '0;
         end
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         tick_dly_q   <= tick_dly_d;
         stable_q     <= stable_d;
         fire_prev_q  <= fire_prev_d;
         coin_prev_q  <= coin_prev_d;
         pause_prev_q <= pause_prev_d;
         coin_state_q <= coin_state_d;
         coin_cnt_q   <= coin_cnt_d;
         coin_q       <= coin_d;
         p_left_q     <= p_left_d;
         p_right_q    <= p_right_d;
         p_start_q    <= p_start_d;
         p_fire_q     <= p_fire_d;
         pause_q      <= pause_d;
         for (int i = 0; i < NS; i++) begin
            deb_cnt_q[i] <= deb_cnt_d[i];
         end
         for (int k = 0; k < NUM_PLAYERS; k++) begin
            af_phase_q[k] <= af_phase_d[k];
         end
      end
   end

   assign p_left  = p_left_q;
   assign p_right = p_right_q;
   assign p_start = p_start_q;
   assign p_fire  = p_fire_q;
   assign coin    = coin_q;
   assign pause   = pause_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench for arcade_input_mapper: stimulus pushes expected output transitions
// (edge number + full output vector); a monitor pops one entry on every output change.
module tb_arcade_input_mapper;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [31:0] joy_in;
   logic        mode_indep;
   logic [1:0]  autofire_en;
   logic [1:0]  p_left, p_right, p_fire, p_start;
   logic        coin, pause;

   arcade_input_mapper #(
      .NUM_PLAYERS(2),
      .TICK_DIV   (4),
      .DEB_TICKS  (3),
      .COIN_TICKS (5),
      .AF_TICKS   (2)
   ) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .joy_in     (joy_in),
      .mode_indep (mode_indep),
      .autofire_en(autofire_en),
      .p_left     (p_left),
      .p_right    (p_right),
      .p_fire     (p_fire),
      .p_start    (p_start),
      .coin       (coin),
      .pause      (pause)
   );

   always #5 clk_sys = ~clk_sys;

   // Number of rising edges seen so far; at a negedge it names the edge just taken.
   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   typedef struct {
      int         at_edge;
      logic [9:0] vec;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [9:0] dut_vec;
   assign dut_vec = {pause, coin, p_start, p_fire, p_right, p_left};

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic logic [9:0] mk(input logic [1:0] l, input logic [1:0] r, input logic [1:0] f,
                                     input logic [1:0] s, input logic c, input logic p);
      return {p, c, s, f, r, l};
   endfunction

   task automatic push(input int at_edge, input logic [9:0] v);
      exp_t e;
      e.at_edge = at_edge;
      e.vec     = v;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk_sys);
   endtask

   // Monitor: every output change must match the next expected transition, value and edge.
   initial begin : monitor
      logic [9:0] last_vec;
      exp_t       e;
      last_vec = '0;
      forever begin
         @(negedge clk_sys);
         if (cyc >= 1 && dut_vec !== last_vec) begin
            if (exp_q.size() == 0) begin
               check("unexpected_change", 32'(dut_vec), 32'(last_vec));
            end else begin
               e = exp_q.pop_front();
               check($sformatf("out_vec@%0d", e.at_edge), 32'(dut_vec), 32'(e.vec));
               check($sformatf("out_edge@%0d", e.at_edge), 32'(cyc), 32'(e.at_edge));
            end
            last_vec = dut_vec;
         end
      end
   end

   initial begin : stimulus
      reset       = 1'b1;
      joy_in      = '1;
      mode_indep  = 1'b0;
      autofire_en = 2'b00;

      // Reset with every pad bit held high; ticks then fall on edges 6, 10, 14 ...
      push(15, mk(2'b00, 2'b00, 2'b11, 2'b11, 1'b1, 1'b1));
      push(35, mk(2'b00, 2'b00, 2'b11, 2'b11, 1'b0, 1'b1));
      wait_until(2);
      reset = 1'b0;
      wait_until(3);
      check("reset_release_outputs", 32'(dut_vec), 32'd0);
      wait_until(40);
      joy_in = '0;
      push(51, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));

      // Re-reset to clear pause; ticks now at 65, 69, ... (61 + 4k).
      wait_until(60);
      reset = 1'b1;
      push(61, 10'd0);
      wait_until(61);
      reset = 1'b0;

      // Debounce: a 2-tick glitch is swallowed, a long hold passes after 3 ticks.
      wait_until(70);
      joy_in[4] = 1'b1;
      wait_until(78);
      joy_in[4] = 1'b0;
      wait_until(90);
      joy_in[4] = 1'b1;
      push(102, mk(2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
      wait_until(110);
      joy_in[4] = 1'b0;
      push(122, 10'd0);

      // Independent mode with SOCD on pad 1.
      wait_until(130);
      mode_indep = 1'b1;
      joy_in     = 32'h0003_0000;
      wait_until(145);
      check("socd_left", 32'(p_left), 32'd0);
      check("socd_right", 32'(p_right), 32'd0);
      wait_until(150);
      joy_in = 32'h0022_0001;
      push(162, mk(2'b10, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0));
      wait_until(170);
      joy_in = '0;
      push(182, 10'd0);
      wait_until(190);
      mode_indep = 1'b0;

      // Coin: long hold gives one 20-cycle pulse; a fresh press gives another.
      wait_until(200);
      joy_in[7] = 1'b1;
      push(210, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
      push(230, 10'd0);
      wait_until(400);
      joy_in[7] = 1'b0;
      wait_until(420);
      joy_in[7] = 1'b1;
      push(430, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
      push(450, 10'd0);
      wait_until(460);
      joy_in[7] = 1'b0;

      // Autofire on player 0 only; player 1 follows the held button.
      wait_until(480);
      autofire_en = 2'b01;
      joy_in[4]   = 1'b1;
      push(490, mk(2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
      push(498, mk(2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
      push(506, mk(2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
      push(514, mk(2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
      push(522, mk(2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
      push(530, mk(2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
      wait_until(525);
      joy_in[4] = 1'b0;
      push(538, 10'd0);

      // Autofire disabled while held: player 0 snaps back to steady fire.
      wait_until(550);
      joy_in[4] = 1'b1;
      push(562, mk(2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
      push(570, mk(2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
      wait_until(572);
      autofire_en = 2'b00;
      push(573, mk(2'b00, 2'b00, 2'b11, 2'b00, 1'b0, 1'b0));
      wait_until(580);
      joy_in[4] = 1'b0;
      push(590, 10'd0);

      // Pause toggles once per press.
      wait_until(600);
      joy_in[8] = 1'b1;
      push(610, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1));
      wait_until(620);
      joy_in[8] = 1'b0;
      wait_until(640);
      joy_in[8] = 1'b1;
      push(650, 10'd0);
      wait_until(660);
      joy_in[8] = 1'b0;

      // Reset during a coin pulse, then a new press proves the FSM restarted from idle.
      wait_until(680);
      joy_in[7] = 1'b1;
      push(690, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
      wait_until(695);
      reset  = 1'b1;
      joy_in = '0;
      push(696, 10'd0);
      wait_until(697);
      reset = 1'b0;
      wait_until(700);
      joy_in[7] = 1'b1;
      push(710, mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0));
      push(730, 10'd0);
      wait_until(740);
      joy_in[7] = 1'b0;

      wait_until(770);
      check("pending_expectations", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
